// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer between a CPU request port and a sync-read RAM
// Ports: clk/rst_n (async active-low); req_* CPU request (valid/ready, we, funct3, addr, wdata);
// resp_* one-cycle completion (valid, rdata, err); mem_r_addr/mem_r_val RAM read port (1-cycle latency);
// mem_w_enable/mem_w_addr/mem_w_val/mem_byte_en RAM write port.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses; otherwise they are aligned down.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [29:0] mem_r_addr,
  input  logic [31:0] mem_r_val,
  output logic        mem_w_enable,
  output logic [29:0] mem_w_addr,
  output logic [31:0] mem_w_val,
  output logic [3:0]  mem_byte_en
);
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RESP} state_t;
  state_t st, st_n;
  logic we_q, err_q, acc, ill, mis, err_n;
  logic [2:0] f3_q;
  logic [31:0] a_q, wd_q, rd_q, a_n, sb, sh, ld_ext;
  assign req_ready = (st == IDLE) || (st == RESP);
  assign acc = req_valid && req_ready;
  assign ill = req_we ? (req_funct3 >= 3'd3) : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
  assign mis = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
  assign err_n = ill || mis;
  assign a_n = req_addr;
`else
  // halfword drops addr[0], word drops addr[1:0]; byte keeps both
  assign err_n = ill;
  assign a_n = {req_addr[31:2], req_addr[1] & ~req_funct3[1], req_addr[0] & ~(req_funct3[1] | req_funct3[0])};
`endif
  always_comb begin
    st_n = st;
    unique case (st)
      IDLE, RESP: st_n = acc ? (err_n ? RESP : (req_we ? WR : RD_ADDR)) : IDLE;
      WR:         st_n = RESP;
      RD_ADDR:    st_n = RD_DATA;
      RD_DATA:    st_n = RESP;
      default:    st_n = IDLE;
    endcase
  end
  assign sb = mem_r_val >> {a_q[1:0], 3'b000};
  assign sh = mem_r_val >> {a_q[1], 4'b0000};
  assign ld_ext = f3_q[1:0] == 2'd0 ? {{24{sb[7] & ~f3_q[2]}}, sb[7:0]} :
                  f3_q[1:0] == 2'd1 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : mem_r_val;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      f3_q  <= 3'd0;
      a_q   <= 32'd0;
      wd_q  <= 32'd0;
      rd_q  <= 32'd0;
    end else begin
      st <= st_n;
      if (acc) begin
        we_q  <= req_we;
        err_q <= err_n;
        f3_q  <= req_funct3;
        a_q   <= a_n;
        wd_q  <= req_wdata;
        rd_q  <= 32'd0;
      end else if (st == RD_DATA) rd_q <= ld_ext;
    end
  end
  assign mem_r_addr   = a_q[31:2];
  assign mem_w_addr   = a_q[31:2];
  assign mem_w_enable = (st == WR) && we_q;
  // the RAM writes on byte enables alone, so they must stay zero outside WR
  assign mem_byte_en  = !mem_w_enable ? 4'b0000 :
                        f3_q[1:0] == 2'd0 ? 4'b0001 << a_q[1:0] :
                        f3_q[1:0] == 2'd1 ? (a_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mem_w_val    = f3_q[1:0] == 2'd0 ? {4{wd_q[7:0]}} :
                        f3_q[1:0] == 2'd1 ? {2{wd_q[15:0]}} : wd_q;
  assign resp_valid   = (st == RESP);
  assign resp_err     = resp_valid && err_q;
  assign resp_rdata   = resp_valid ? rd_q : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a byte-enable RAM model
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic resp_valid, resp_err, mem_w_enable;
  logic [31:0] resp_rdata, mem_r_val, mem_w_val;
  logic [29:0] mem_r_addr, mem_w_addr;
  logic [3:0] mem_byte_en;
  logic [31:0] ram [0:1023];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_r_addr(mem_r_addr), .mem_r_val(mem_r_val),
    .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr), .mem_w_val(mem_w_val), .mem_byte_en(mem_byte_en)
  );
  initial for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
  always @(posedge clk) begin
    mem_r_val <= ram[mem_r_addr[9:0]];
    for (int b = 0; b < 4; b++) if (mem_byte_en[b]) ram[mem_w_addr[9:0]][8*b +: 8] <= mem_w_val[8*b +: 8];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [29:0] wa, input logic [3:0] be, input logic [31:0] wv);
    go(1'b1, f3, a, wd);
    @(negedge clk);
    chk("st_wen", {31'd0, mem_w_enable}, 32'd1);
    chk("st_waddr", {2'd0, mem_w_addr}, {2'd0, wa});
    chk("st_be", {28'd0, mem_byte_en}, {28'd0, be});
    chk("st_wval", mem_w_val, wv);
    chk("st_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("st_resp", {31'd0, resp_valid}, 32'd1);
    chk("st_rdata", resp_rdata, 32'd0);
    chk("st_err", {31'd0, resp_err}, 32'd0);
    chk("st_be_resp", {28'd0, mem_byte_en}, 32'd0);
  endtask
  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [29:0] ra, input logic [31:0] exp);
    go(1'b0, f3, a, 32'd0);
    @(negedge clk);
    chk("ld_raddr", {2'd0, mem_r_addr}, {2'd0, ra});
    chk("ld_be", {28'd0, mem_byte_en}, 32'd0);
    chk("ld_early1", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("ld_early2", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("ld_resp", {31'd0, resp_valid}, 32'd1);
    chk("ld_rdata", resp_rdata, exp);
    chk("ld_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    chk("ld_pulse", {31'd0, resp_valid}, 32'd0);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_wen", {31'd0, mem_w_enable}, 32'd0);
    chk("rst_be", {28'd0, mem_byte_en}, 32'd0);
    chk("rst_raddr", {2'd0, mem_r_addr}, 32'd0);
    chk("rst_waddr", {2'd0, mem_w_addr}, 32'd0);
    chk("rst_wval", mem_w_val, 32'd0);
    rst_n = 1'b1;
    store(3'd2, 32'h10, 32'hDEADBEEF, 30'd4, 4'b1111, 32'hDEADBEEF);
    load(3'd2, 32'h10, 30'd4, 32'hDEADBEEF);
    store(3'd0, 32'h13, 32'h000000AB, 30'd4, 4'b1000, 32'hABABABAB);
    load(3'd0, 32'h13, 30'd4, 32'hFFFFFFAB);
    load(3'd4, 32'h13, 30'd4, 32'h000000AB);
    load(3'd2, 32'h10, 30'd4, 32'hABADBEEF);
    store(3'd1, 32'h22, 32'h00008001, 30'd8, 4'b1100, 32'h80018001);
    load(3'd1, 32'h22, 30'd8, 32'hFFFF8001);
    load(3'd5, 32'h22, 30'd8, 32'h00008001);
    load(3'd0, 32'h11, 30'd4, 32'hFFFFFFBE);
`ifdef LSU_MISALIGN_TRAP_EN
    go(1'b0, 3'd2, 32'h21, 32'd0);
    @(negedge clk);
    chk("mis_resp", {31'd0, resp_valid}, 32'd1);
    chk("mis_err", {31'd0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
`else
    load(3'd2, 32'h21, 30'd8, 32'h80010000);
`endif
    go(1'b1, 3'd4, 32'h30, 32'h55);
    @(negedge clk);
    chk("ill_st_resp", {31'd0, resp_valid}, 32'd1);
    chk("ill_st_err", {31'd0, resp_err}, 32'd1);
    chk("ill_st_be", {28'd0, mem_byte_en}, 32'd0);
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'd3; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_funct3 = 3'd2;
    @(negedge clk);
    chk("ill_ld_resp", {31'd0, resp_valid}, 32'd1);
    chk("ill_ld_err", {31'd0, resp_err}, 32'd1);
    chk("ill_ld_rdata", resp_rdata, 32'd0);
    chk("ill_ld_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, req_ready}, 32'd0);
    chk("b2b_raddr", {2'd0, mem_r_addr}, 32'd4);
    chk("b2b_novalid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_wait", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_resp", {31'd0, resp_valid}, 32'd1);
    chk("b2b_rdata", resp_rdata, 32'hABADBEEF);
    go(1'b1, 3'd2, 32'h40, 32'h12345678);
    @(negedge clk);
    chk("abort_be_pre", {28'd0, mem_byte_en}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("abort_be", {28'd0, mem_byte_en}, 32'd0);
    chk("abort_wen", {31'd0, mem_w_enable}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("abort_noresp", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_noresp2", {31'd0, resp_valid}, 32'd0);
    load(3'd2, 32'h40, 30'd16, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
